// File: rtl/noc_pipeline_link.sv
// -----------------------------------------------------------------------------
// noc_pipeline_link
//
// Pipelined point-to-point link between two credit-based NoC routers.
// The forward path (send/data/dest/tail) and the credit return path each
// run through their own NUM_PIPELINE-deep shift register. Both advance every
// cycle and never stall. With NUM_PIPELINE = 0 both paths are plain wires.
//
// The link also keeps an upstream-view credit counter and a sticky protocol
// error flag. Both are monitoring outputs only: they never gate, drop or
// create flits or credits.
//
// Ports
//   clk           link clock (single domain)
//   rst_n         asynchronous active-low reset
//   data_in       flit payload from the upstream router output
//   dest_in       destination field from upstream
//   is_tail_in    tail marker from upstream
//   send_in       flit-valid strobe from upstream
//   credit_out    credit returned to upstream (delayed credit_in)
//   data_out      flit payload to the downstream router input
//   dest_out      destination field to downstream
//   is_tail_out   tail marker to downstream
//   send_out      flit-valid strobe to downstream
//   credit_in     credit from the downstream router
//   credit_count  credits the upstream router should still have available
//   link_error    sticky flag: credit underflow or overflow has been seen
// -----------------------------------------------------------------------------
module noc_pipeline_link #(
   parameter int NUM_PIPELINE      = 0,
   parameter int FLIT_WIDTH        = 64,
   parameter int DEST_WIDTH        = 6,
   parameter int FLIT_BUFFER_DEPTH = 1,
   parameter int CW                = $clog2(FLIT_BUFFER_DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   // upstream side
   input  logic [FLIT_WIDTH-1:0] data_in,
   input  logic [DEST_WIDTH-1:0] dest_in,
   input  logic                  is_tail_in,
   input  logic                  send_in,
   output logic                  credit_out,
   // downstream side
   output logic [FLIT_WIDTH-1:0] data_out,
   output logic [DEST_WIDTH-1:0] dest_out,
   output logic                  is_tail_out,
   output logic                  send_out,
   input  logic                  credit_in,
   // monitoring
   output logic [CW-1:0]         credit_count,
   output logic                  link_error
);

   localparam logic [CW-1:0] DEPTH_C = CW'(FLIT_BUFFER_DEPTH);

   // --------------------------------------------------------------------------
   // Forward and credit paths
   // --------------------------------------------------------------------------
   generate
      if (NUM_PIPELINE == 0) begin : g_wire
         assign data_out    = data_in;
         assign dest_out    = dest_in;
         assign is_tail_out = is_tail_in;
         assign send_out    = send_in;
         assign credit_out  = credit_in;
      end else begin : g_pipe
         // Stage 0 is the entry register; stage NUM_PIPELINE-1 drives outputs.
         logic [NUM_PIPELINE-1:0] r_send_q;
         logic [NUM_PIPELINE-1:0] r_tail_q;
         logic [NUM_PIPELINE-1:0] r_credit_q;
         logic [FLIT_WIDTH-1:0]   r_data_q [NUM_PIPELINE];
         logic [DEST_WIDTH-1:0]   r_dest_q [NUM_PIPELINE];

         // Valid bits: send and credit travel in separate shift registers so a
         // credit can never merge with or be held up by a flit.
         // NOTE: sequential state uses non-blocking assignments so every stage
         // samples the value its neighbour held before this edge.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_send_q   <= '0;
               r_tail_q   <= '0;
               r_credit_q <= '0;
            end else begin
               r_send_q[0]   <= send_in;
               r_tail_q[0]   <= is_tail_in;
               r_credit_q[0] <= credit_in;
               for (int i = 1; i < NUM_PIPELINE; i++) begin
                  r_send_q[i]   <= r_send_q[i-1];
                  r_tail_q[i]   <= r_tail_q[i-1];
                  r_credit_q[i] <= r_credit_q[i-1];
               end
            end
         end

         // Payload stages load every cycle regardless of send; the consumer
         // ignores them while send_out is low.
         // NOTE: these payload registers are reset on purpose so data_out and
         // dest_out read zero out of reset; a wide datapath that did not need
         // defined idle values could drop this reset.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               for (int i = 0; i < NUM_PIPELINE; i++) begin
                  r_data_q[i] <= '0;
                  r_dest_q[i] <= '0;
               end
            end else begin
               r_data_q[0] <= data_in;
               r_dest_q[0] <= dest_in;
               for (int i = 1; i < NUM_PIPELINE; i++) begin
                  r_data_q[i] <= r_data_q[i-1];
                  r_dest_q[i] <= r_dest_q[i-1];
               end
            end
         end

         assign send_out    = r_send_q[NUM_PIPELINE-1];
         assign is_tail_out = r_tail_q[NUM_PIPELINE-1];
         assign credit_out  = r_credit_q[NUM_PIPELINE-1];
         assign data_out    = r_data_q[NUM_PIPELINE-1];
         assign dest_out    = r_dest_q[NUM_PIPELINE-1];
      end
   endgenerate

   // --------------------------------------------------------------------------
   // Upstream-view credit monitor
   //
   // A flit leaving upstream (send_in) consumes a credit; a credit arriving
   // back at upstream (credit_out) restores one. Both in the same cycle cancel.
   // The counter saturates at 0 and at FLIT_BUFFER_DEPTH, and any attempt to
   // cross either bound latches link_error.
   // --------------------------------------------------------------------------
   logic [CW-1:0] r_credit_count;
   logic          r_link_error;
   logic [CW-1:0] w_count_next;
   logic          w_underflow;
   logic          w_overflow;

   // Underflow is flagged even when a credit returns in the same cycle: the
   // upstream router sent a flit it had no credit for at the moment it sent.
   assign w_underflow = send_in && (r_credit_count == '0);
   assign w_overflow  = credit_out && !send_in && (r_credit_count == DEPTH_C);

   // NOTE: the next-count value gets its default first so every path through
   // the block assigns it and no latch is inferred.
   always_comb begin
      w_count_next = r_credit_count;
      if (send_in && !credit_out && (r_credit_count != '0)) begin
         w_count_next = r_credit_count - CW'(1);
      end else if (credit_out && !send_in && (r_credit_count != DEPTH_C)) begin
         w_count_next = r_credit_count + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_credit_count <= DEPTH_C;
         r_link_error   <= 1'b0;
      end else begin
         r_credit_count <= w_count_next;
         if (w_underflow || w_overflow) begin
            r_link_error <= 1'b1;
         end
      end
   end

   assign credit_count = r_credit_count;
   assign link_error   = r_link_error;

endmodule

// File: doc/noc_pipeline_link.md
NOC_PIPELINE_LINK -- requirements
Module: noc_pipeline_link

Interface
REQ-001 Parameter NUM_PIPELINE, default 0: number of register stages on the forward path and, separately, on the credit return path.
REQ-002 Parameter FLIT_WIDTH, default 64: flit payload width.
REQ-003 Parameter DEST_WIDTH, default 6: destination field width.
REQ-004 Parameter FLIT_BUFFER_DEPTH, default 1: downstream input buffer depth, and therefore the credit budget.
REQ-005 Derived CW = $clog2(FLIT_BUFFER_DEPTH+1), the credit counter width.
REQ-006 clk  input  1  link clock; one clock domain only.
REQ-007 rst_n  input  1  reset, asynchronous, active-low.
REQ-008 data_in  input  FLIT_WIDTH  flit from the upstream router output.
REQ-009 dest_in  input  DEST_WIDTH  destination from upstream.
REQ-010 is_tail_in  input  1  tail marker from upstream.
REQ-011 send_in  input  1  flit-valid strobe from upstream.
REQ-012 credit_out  output  1  credit returned to upstream.
REQ-013 data_out  output  FLIT_WIDTH  flit to the downstream router input.
REQ-014 dest_out  output  DEST_WIDTH  destination to downstream.
REQ-015 is_tail_out  output  1  tail marker to downstream.
REQ-016 send_out  output  1  flit-valid strobe to downstream.
REQ-017 credit_in  input  1  credit from the downstream router.
REQ-018 credit_count  output  CW  upstream-view credits available.
REQ-019 link_error  output  1  sticky protocol violation flag.

Function
REQ-020 NUM_PIPELINE=0: forward and credit paths are pure wires.
- data_out=data_in, dest_out=dest_in, is_tail_out=is_tail_in, send_out=send_in, credit_out=credit_in.
REQ-021 NUM_PIPELINE=N>0: send, data, dest and tail pass through an N-deep shift register.
- Each field appears at the output exactly N cycles after entry.
- The stages advance every cycle, with no stall.
REQ-022 NUM_PIPELINE=N>0: credit_in passes through an independent N-deep shift register, so credit_out equals credit_in delayed N cycles.
REQ-023 Data, dest and tail stage registers load unconditionally each cycle.
- When send_out=0, the values of data_out, dest_out and is_tail_out are don't-care for the consumer.
REQ-024 Back-to-back flits (send_in=1 on consecutive cycles) emerge on consecutive cycles, in order, with no loss or duplication.
REQ-025 Back-to-back credits (credit_in=1 on consecutive cycles) emerge on consecutive cycles with no merging.
REQ-026 credit_count is a registered counter, loaded with FLIT_BUFFER_DEPTH at reset.
REQ-027 credit_count update each cycle:
- send_in only: decrement by 1.
- credit_out only: increment by 1.
- Both or neither: hold.
REQ-028 Underflow: send_in=1 while credit_count=0 sets link_error the next cycle, regardless of a same-cycle credit_out; the counter holds at 0 (saturates).
REQ-029 Overflow: credit_out=1 with send_in=0 while credit_count=FLIT_BUFFER_DEPTH sets link_error the next cycle; the counter holds at FLIT_BUFFER_DEPTH (saturates).
REQ-030 link_error stays 1 until reset; the data path keeps forwarding flits and credits unchanged after an error.
REQ-031 The link does not modify, drop or generate flits or credits; credit_count and link_error are monitoring outputs only.
REQ-032 Round-trip credit latency added by the link is 2*NUM_PIPELINE cycles; upstream credit sizing is outside this block.

Reset
REQ-033 While rst_n=0, all stage valid bits, data/dest/tail stages and credit stages are cleared to 0 asynchronously.
REQ-034 Reset values of outputs:
- With NUM_PIPELINE>0: send_out=0, credit_out=0, data_out=0, dest_out=0, is_tail_out=0.
- For any NUM_PIPELINE: credit_count=FLIT_BUFFER_DEPTH, link_error=0.
REQ-035 Reset asserted mid-operation discards all in-flight flits and credits; no send_out or credit_out pulse occurs after rst_n rises until new input arrives.
REQ-036 The first cycle after rst_n deassertion accepts send_in and credit_in normally.

Verification
REQ-037 N=2, depth 4: send_in pulses at cycles 10,11,12 with data 0xA,0xB,0xC (tail on 0xC) -> send_out at 12,13,14 carrying 0xA,0xB,0xC, with is_tail_out=1 only at 14.
REQ-038 N=2: credit_in pulses at cycles 20,21 -> credit_out at 22,23; credit_count follows per REQ-027.
REQ-039 N=0: random send/data/credit stimulus -> outputs equal inputs in the same cycle.
REQ-040 Depth 1: send_in at cycle 5, then send_in again at cycle 6 with no credit returned -> credit_count 1->0 after cycle 5; link_error=1 from cycle 7 and stays set.
REQ-041 Depth 2, count=2: credit_in pulse with no prior send -> link_error=1 the cycle after credit_out, and the count stays at 2.
REQ-042 N=3: rst_n low for 1 cycle while 3 flits are in flight -> no send_out afterwards, credit_count=depth, link_error=0.
